// File: rtl/adc_sample_source.sv
// Deterministic ADC stand-in: on request, waits CONV_LAT cycles, then streams
// BURST_LEN signed samples from a free-running ramp or a Fibonacci LFSR.
module adc_sample_source #(
  parameter int                DATA_W    = 12,
  parameter int                BURST_LEN = 8,
  parameter int                CONV_LAT  = 10,
  parameter logic [DATA_W-1:0] LFSR_SEED = DATA_W'(12'hACE)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     adc_data_req_i,
  input  logic                     mode_i,
  input  logic                     clr_missed_i,
  output logic                     adc_data_rdy_o,
  output logic signed [DATA_W-1:0] adc_data_o,
  output logic                     busy_o,
  output logic                     missed_req_o
);

  localparam int LAT_W    = $clog2(CONV_LAT + 1);
  localparam int REM_W    = $clog2(BURST_LEN + 1);
  localparam int LAT_INIT = (CONV_LAT > 1) ? CONV_LAT - 2 : 0;

  // Maximal-length taps, bit t-1 set for polynomial tap t, shifting toward the MSB.
  function automatic logic [15:0] tap_mask(input int w);
    case (w)
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      default: return 16'hD008;
    endcase
  endfunction

  localparam logic [15:0]       TAP_ALL = tap_mask(DATA_W);
  localparam logic [DATA_W-1:0] TAPS    = TAP_ALL[DATA_W-1:0];

  function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] q);
    return {q[DATA_W-2:0], ^(q & TAPS)};
  endfunction

  function automatic logic signed [DATA_W-1:0] ramp_next(input logic signed [DATA_W-1:0] v);
    return v + $signed({{(DATA_W-1){1'b0}}, 1'b1});
  endfunction

  typedef enum logic [1:0] {IDLE, CONV, BURST} state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic                       w_accept;
  logic                       w_emit;
  logic                       w_miss;
  logic [LAT_W-1:0]           r_lat;
  logic [REM_W-1:0]           r_rem;
  logic                       r_mode;
  logic signed [DATA_W-1:0]   r_ramp;
  logic [DATA_W-1:0]          r_lfsr;

  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // A BURST state with no samples left is the exit edge and behaves like IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_emit      = 1'b0;
    w_miss      = 1'b0;
    case (r_state)
      IDLE: w_accept = adc_data_req_i;
      CONV: begin
        w_miss = adc_data_req_i;
        if (r_lat == '0) w_state_nxt = BURST;
      end
      BURST: begin
        if (r_rem != '0) begin
          w_emit = 1'b1;
          w_miss = adc_data_req_i;
        end else begin
          w_state_nxt = IDLE;
          w_accept    = adc_data_req_i;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_accept) w_state_nxt = (CONV_LAT == 1) ? BURST : CONV;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_o         <= 1'b0;
      adc_data_rdy_o <= 1'b0;
      missed_req_o   <= 1'b0;
      r_lat          <= '0;
      r_rem          <= '0;
      r_mode         <= 1'b0;
    end else begin
      busy_o         <= (w_state_nxt != IDLE);
      adc_data_rdy_o <= w_emit;
      if (w_accept) begin
        r_mode <= mode_i;
        r_lat  <= LAT_W'(LAT_INIT);
      end else if (r_state == CONV && r_lat != '0) begin
        r_lat <= r_lat - 1'b1;
      end
      if (r_state != BURST && w_state_nxt == BURST) r_rem <= REM_W'(BURST_LEN);
      else if (w_emit)                              r_rem <= r_rem - 1'b1;
      if (w_miss)            missed_req_o <= 1'b1;
      else if (clr_missed_i) missed_req_o <= 1'b0;
    end
  end

  // Sample sources persist across bursts; only the one latched for the burst advances.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      adc_data_o <= '0;
      r_ramp     <= '0;
      r_lfsr     <= LFSR_SEED;
    end else if (w_emit) begin
      if (r_mode) begin
        adc_data_o <= $signed(r_lfsr);
        r_lfsr     <= lfsr_next(r_lfsr);
      end else begin
        adc_data_o <= r_ramp;
        r_ramp     <= ramp_next(r_ramp);
      end
    end
  end

endmodule
